// File: rtl/shooter_pkg.sv
// Shared constants and sprite-mask helpers for the shooter playfield engine.
package shooter_pkg;

    localparam int MUZZLE_COL = 3;
    localparam int SCORE_W = 8;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;
    localparam int MAX_COLS = 64;

    typedef logic [MAX_COLS-1:0] mask_t;

    // Player sprite: three-wide base on its own lane, single pixel on neighbours.
    function automatic mask_t player_mask(input logic centre);
        return centre ? mask_t'(3'b111) : mask_t'(1'b1);
    endfunction

    // Enemy sprite sits at the far edge, two wide on its lane, one on neighbours.
    function automatic mask_t enemy_mask(input int cols, input logic centre);
        return centre ? (mask_t'(2'b11) << (cols - 2)) : (mask_t'(1'b1) << (cols - 1));
    endfunction

endpackage

// File: rtl/shooter_scan.sv
// Row-scanned LED matrix driver: steps one scanline every SCAN_DIV clocks, top row first.
module shooter_scan
    import shooter_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 16,
    parameter int SCAN_DIV = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ROWS-1:0][COLS-1:0]  frame,
    output logic [ROWS-1:0]            row,
    output logic [COLS-1:0]            col
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int LW = $clog2(ROWS);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [LW-1:0] LINE_TOP = LW'(ROWS - 1);

    logic [SW-1:0] scan_cnt;
    logic [LW-1:0] scanline;
    logic          step;

    assign step = (scan_cnt == SCAN_LAST);

    // Scan divider, scanline countdown and the row/col pin registers, updated together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt <= '0;
            scanline <= LINE_TOP;
            row      <= '1;
            col      <= '0;
        end else if (step) begin
            scan_cnt <= '0;
            scanline <= (scanline == '0) ? LINE_TOP : scanline - LW'(1);
            row      <= ~(ROWS'(1) << scanline);
            col      <= frame[scanline];
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/shooter_field.sv
// Playfield engine: tick divider, fire capture, bullet shifting, collisions and score.
// Optional autofire is compiled in with `define SHOOTER_AUTOFIRE_EN.
module shooter_field
    import shooter_pkg::*;
#(
    parameter int          ROWS = 8,
    parameter int          COLS = 16,
    parameter int          SCAN_DIV = 1000,
    parameter logic [24:0] TICK_DIV = 25'd4194304,
    parameter int          AUTOFIRE_TICKS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [$clog2(ROWS)-1:0]   player_pos,
    input  logic [$clog2(ROWS)-1:0]   enemy_pos,
    input  logic                      fire,
    output logic [ROWS-1:0]           row,
    output logic [COLS-1:0]           col,
    output logic                      hit,
    output logic [SCORE_W-1:0]        score
);

    localparam int TW = (TICK_DIV > 25'd1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 25'd1);
    localparam int CW = $clog2(ROWS * COLS + 1);

    logic [TW-1:0]             tick_cnt;
    logic                      tick_en;
    logic                      fire_prev;
    logic                      fire_edge;
    logic                      fire_pending;
    logic                      auto_req;
    logic                      shot_req;
    logic [ROWS-1:0][COLS-1:0] bullets;
    logic [ROWS-1:0][COLS-1:0] bullets_next;
    logic [ROWS-1:0][COLS-1:0] frame;
    logic [CW-1:0]             clear_cnt;
    logic [SCORE_W-1:0]        score_next;

    function automatic logic [COLS-1:0] player_lane(input int lane, input int pos);
        mask_t m;
        if (lane == pos) m = player_mask(1'b1);
        else if (lane == pos - 1 || lane == pos + 1) m = player_mask(1'b0);
        else m = '0;
        return m[COLS-1:0];
    endfunction

    function automatic logic [COLS-1:0] enemy_lane(input int lane, input int pos);
        mask_t m;
        if (lane == pos) m = enemy_mask(COLS, 1'b1);
        else if (lane == pos - 1 || lane == pos + 1) m = enemy_mask(COLS, 1'b0);
        else m = '0;
        return m[COLS-1:0];
    endfunction

    function automatic logic [CW-1:0] bit_count(input logic [COLS-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < COLS; i++) n = n + CW'(v[i]);
        return n;
    endfunction

    assign tick_en   = (tick_cnt == TICK_LAST);
    assign fire_edge = fire & ~fire_prev;
    assign shot_req  = fire_edge | auto_req;

    // Game tick divider.
    always_ff @(posedge clk) begin
        if (!rst) tick_cnt <= '0;
        else if (tick_en) tick_cnt <= '0;
        else tick_cnt <= tick_cnt + TW'(1);
    end

`ifdef SHOOTER_AUTOFIRE_EN
    localparam int AW = (AUTOFIRE_TICKS > 1) ? $clog2(AUTOFIRE_TICKS) : 1;
    logic [AW-1:0] af_cnt;

    // The press edge fires the first shot; a repeat is queued every AUTOFIRE_TICKS ticks held.
    assign auto_req = fire & tick_en & (af_cnt == AW'(AUTOFIRE_TICKS - 1));

    // Autofire tick counter, cleared whenever the button is released.
    always_ff @(posedge clk) begin
        if (!rst) af_cnt <= '0;
        else if (!fire) af_cnt <= '0;
        else if (tick_en) af_cnt <= auto_req ? '0 : af_cnt + AW'(1);
        else af_cnt <= af_cnt;
    end
`else
    // Autofire compiled out; the constant-false term keeps the parameter referenced.
    assign auto_req = (AUTOFIRE_TICKS < 0);
`endif

    // Next bullet state for a tick: shift, inject at the muzzle, then strip enemy overlaps.
    always_comb begin
        logic [COLS-1:0] shifted;
        logic [COLS-1:0] hits;
        shifted      = '0;
        hits         = '0;
        bullets_next = bullets;
        clear_cnt    = '0;
        for (int r = 0; r < ROWS; r++) begin
            shifted = bullets[r] << 1;
            if (fire_pending && r == int'(player_pos)) shifted = shifted | (COLS'(1) << MUZZLE_COL);
            else shifted = shifted;
            hits            = shifted & enemy_lane(r, int'(enemy_pos));
            bullets_next[r] = shifted & ~hits;
            clear_cnt       = clear_cnt + bit_count(hits);
        end
    end

    // Saturating score add.
    always_comb begin
        int total;
        total = int'(score) + int'(clear_cnt);
        if (total > int'(SCORE_MAX)) score_next = SCORE_MAX;
        else score_next = SCORE_W'(total);
    end

    // Displayed frame follows positions live.
    always_comb begin
        frame = '0;
        for (int r = 0; r < ROWS; r++) begin
            frame[r] = bullets[r] | player_lane(r, int'(player_pos)) | enemy_lane(r, int'(enemy_pos));
        end
    end

    // Fire capture, bullet bitmaps, hit pulse and score; a shot requested on the tick waits a tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fire_prev    <= 1'b0;
            fire_pending <= 1'b0;
            bullets      <= '0;
            hit          <= 1'b0;
            score        <= '0;
        end else begin
            fire_prev <= fire;
            if (tick_en) begin
                fire_pending <= shot_req;
                bullets      <= bullets_next;
                hit          <= (clear_cnt != '0);
                score        <= score_next;
            end else begin
                fire_pending <= fire_pending | shot_req;
                hit          <= 1'b0;
            end
        end
    end

    shooter_scan #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk   (clk),
        .rst   (rst),
        .frame (frame),
        .row   (row),
        .col   (col)
    );

endmodule

// File: tb/tb_shooter_field.sv
// Directed bench for shooter_field: reset, shot travel, miss, hit, clipping, saturation, autofire.
module tb_shooter_field;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   player_pos;
    logic [2:0]   enemy_pos;
    logic         fire;
    logic [7:0]   row;
    logic [15:0]  col;
    logic         hit;
    logic [7:0]   score;

    int errors = 0;
    int checks = 0;

    shooter_field #(
        .ROWS           (8),
        .COLS           (16),
        .SCAN_DIV       (2),
        .TICK_DIV       (25'd4),
        .AUTOFIRE_TICKS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .player_pos (player_pos),
        .enemy_pos  (enemy_pos),
        .fire       (fire),
        .row        (row),
        .col        (col),
        .hit        (hit),
        .score      (score)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic do_reset();
        fire = 1'b0;
        rst  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Returns #1 after the clock edge that applied the next tick.
    task automatic next_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (dut.tick_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout_fail("tick_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic fire_pulse();
        fire = 1'b1;
        @(posedge clk);
        #1;
        fire = 1'b0;
    endtask

    // Waits for a fresh scan of the given lane and leaves the bench on a negedge.
    task automatic wait_lane(input int lane);
        logic [7:0] target;
        int n;
        target = ~(8'd1 << lane);
        n = 0;
        @(negedge clk);
        while (row === target && n < 64) begin
            @(negedge clk);
            n++;
        end
        while (row !== target && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) timeout_fail("lane_wait");
    endtask

    initial begin
        logic [7:0][15:0] expb;
        logic             early_hit;

        player_pos = 3'd2;
        enemy_pos  = 3'd6;
        do_reset();
        check("reset_row", 128'(row), 128'(8'hFF));
        check("reset_col", 128'(col), 128'(16'h0000));
        check("reset_score", 128'(score), 128'(8'd0));
        check("reset_hit", 128'(hit), 128'(1'b0));
        check("reset_bullets", dut.bullets, 128'd0);
        rst = 1'b1;

        // Single shot from lane 2, then follow it off the far edge.
        fire_pulse();
        next_tick();
        expb = '0;
        expb[2] = 16'h0008;
        check("shot_bit3", dut.bullets, expb);
        next_tick();
        expb[2] = 16'h0010;
        check("shot_bit4", dut.bullets, expb);
        for (int n = 2; n <= 12; n++) next_tick();
        expb[2] = 16'h8000;
        check("miss_bit15", dut.bullets, expb);
        next_tick();
        check("miss_gone", dut.bullets, 128'd0);
        check("miss_score", 128'(score), 128'(8'd0));

        // Hit: player and enemy in the same lane.
        do_reset();
        rst = 1'b1;
        player_pos = 3'd4;
        enemy_pos  = 3'd4;
        fire_pulse();
        next_tick();
        expb = '0;
        expb[4] = 16'h0008;
        check("hit_inject", dut.bullets, expb);
        early_hit = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            next_tick();
            early_hit = early_hit | hit;
        end
        check("hit_not_early", 128'(early_hit), 128'(1'b0));
        next_tick();
        check("hit_pulse", 128'(hit), 128'(1'b1));
        check("hit_score", 128'(score), 128'(8'd1));
        check("hit_cleared", dut.bullets, 128'd0);
        @(posedge clk);
        #1;
        check("hit_one_cycle", 128'(hit), 128'(1'b0));
        wait_lane(4);
        check("hit_lane4_col", 128'(col), 128'(16'hC007));

        // Sprite clipping at the matrix edges.
        player_pos = 3'd0;
        enemy_pos  = 3'd4;
        wait_lane(1);
        check("clip_lane1", 128'(col), 128'(16'h0001));
        wait_lane(7);
        check("clip_lane7_player", 128'(col), 128'(16'h0000));
        enemy_pos = 3'd7;
        wait_lane(0);
        check("clip_lane0_enemy", 128'(col), 128'(16'h0007));
        wait_lane(7);
        check("clip_lane7_enemy", 128'(col), 128'(16'hC000));

        // Score saturation: one shot per tick, each landing 11 ticks later.
        do_reset();
        rst = 1'b1;
        player_pos = 3'd4;
        enemy_pos  = 3'd4;
        for (int j = 0; j < 280; j++) begin
            fire_pulse();
            next_tick();
            if (j == 210) check("sat_score_200", 128'(score), 128'(8'd200));
        end
        check("sat_score_255", 128'(score), 128'(8'd255));
        check("sat_hit", 128'(hit), 128'(1'b1));

        // Fire held for 12 ticks.
        do_reset();
        rst = 1'b1;
        player_pos = 3'd2;
        enemy_pos  = 3'd6;
        fire = 1'b1;
        for (int n = 0; n < 12; n++) next_tick();
        expb = '0;
`ifdef SHOOTER_AUTOFIRE_EN
        expb[2] = 16'h4440;
`else
        expb[2] = 16'h4000;
`endif
        check("autofire_bullets", dut.bullets, expb);
        fire = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
